// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: datapath widths, load-size encodings, MEM/WB bundle.
// Imported by the write-back stage, its interface and the load formatter.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     read_data;
    logic [DATA_W-1:0]     alu_result;
    logic [1:0]            mem_size;
    logic                  mem_unsigned;
  } mem_wb_t;

endpackage

// File: rtl/write_back_stage_if.sv
// MEM->WB bus: pipeline control, MEM-stage results and the register-file write port.
// slave = write-back stage side, master = MEM stage / register-file side.
interface write_back_stage_if;
  import mips_pkg::*;

  logic                  stall;
  logic                  flush;
  logic                  mem_valid;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0]     read_data;
  logic [DATA_W-1:0]     alu_result;
  logic [1:0]            mem_size;
  logic                  mem_unsigned;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  wb_valid;

  modport slave (
    input  stall, flush, mem_valid, mem_to_reg, reg_write, write_reg,
    input  read_data, alu_result, mem_size, mem_unsigned,
    output rf_we, rf_waddr, rf_wdata, wb_valid
  );

  modport master (
    output stall, flush, mem_valid, mem_to_reg, reg_write, write_reg,
    output read_data, alu_result, mem_size, mem_unsigned,
    input  rf_we, rf_waddr, rf_wdata, wb_valid
  );

endinterface

// File: rtl/write_back_stage_load_formatter.sv
// Big-endian sub-word load formatting: lane select plus sign/zero extension.
// In: read_data, offset, mem_size, mem_unsigned. Out: data (formatted word).
module load_formatter
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] read_data,
  input  logic [1:0]        offset,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = read_data[31:24];
    unique case (offset)
      2'd0: lane_b = read_data[31:24];
      2'd1: lane_b = read_data[23:16];
      2'd2: lane_b = read_data[15:8];
      2'd3: lane_b = read_data[7:0];
    endcase
  end

  // offset[0] ignored for halves: no alignment trap here
  assign lane_h = offset[1] ? read_data[15:0] : read_data[31:16];

  always_comb begin
    data = read_data;
    unique case (1'b1)
      (mem_size == SIZE_BYTE):
        data = {{24{lane_b[7] & ~mem_unsigned}}, lane_b};
      (mem_size == SIZE_HALF):
        data = {{16{lane_h[15] & ~mem_unsigned}}, lane_h};
      default:
        data = read_data;
    endcase
  end

endmodule

// File: rtl/write_back_stage.sv
// MIPS write-back stage: MEM/WB register, load/ALU result mux, $0 write suppression.
// Ports: clk, rst_n (async active-low), bus (write_back_stage_if.slave).
module write_back_stage
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  write_back_stage_if.slave    bus
);

  mem_wb_t r;
  mem_wb_t nxt;
  logic [DATA_W-1:0] ld_data;

  always_comb begin
    nxt.valid        = bus.mem_valid;
    nxt.reg_write    = bus.reg_write;
    nxt.mem_to_reg   = bus.mem_to_reg;
    nxt.write_reg    = bus.write_reg;
    nxt.read_data    = bus.read_data;
    nxt.alu_result   = bus.alu_result;
    nxt.mem_size     = bus.mem_size;
    nxt.mem_unsigned = bus.mem_unsigned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (bus.flush) begin
      r <= '0;
    end else if (!bus.stall) begin
      r <= nxt;
    end
  end

  load_formatter u_fmt (
    .read_data    (r.read_data),
    .offset       (r.alu_result[1:0]),
    .mem_size     (r.mem_size),
    .mem_unsigned (r.mem_unsigned),
    .data         (ld_data)
  );

  assign bus.rf_wdata = r.mem_to_reg ? ld_data : r.alu_result;
  assign bus.rf_we    = r.valid & r.reg_write & (|r.write_reg);
  assign bus.rf_waddr = r.write_reg;
  assign bus.wb_valid = r.valid;

endmodule

// File: tb/tb_write_back_stage.sv
// Directed self-checking bench for write_back_stage.
// Drives the bus after the edge, samples 1ns after the next rising edge.
module tb_write_back_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  write_back_stage_if bus();

  write_back_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic m2r, input logic rw,
                       input logic [4:0] wr, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [1:0] sz,
                       input logic uns);
    bus.mem_valid    = v;
    bus.mem_to_reg   = m2r;
    bus.reg_write    = rw;
    bus.write_reg    = wr;
    bus.read_data    = rd;
    bus.alu_result   = alu;
    bus.mem_size     = sz;
    bus.mem_unsigned = uns;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1, 0, 1, 5'd8, 32'h0, 32'h1, SIZE_WORD, 0);
    #12;
    chk("rst_we", {31'b0, bus.rf_we}, 32'h0);
    chk("rst_waddr", {27'b0, bus.rf_waddr}, 32'h0);
    chk("rst_wdata", bus.rf_wdata, 32'h0);
    chk("rst_valid", {31'b0, bus.wb_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rel_we", {31'b0, bus.rf_we}, 32'h0);

    step();
    chk("alu_wdata", bus.rf_wdata, 32'h1);
    chk("alu_we", {31'b0, bus.rf_we}, 32'h1);
    chk("alu_waddr", {27'b0, bus.rf_waddr}, 32'd8);
    chk("alu_valid", {31'b0, bus.wb_valid}, 32'h1);

    drive(1, 1, 1, 5'd8, 32'h0, 32'h1, SIZE_WORD, 0);
    step();
    chk("lw_wdata", bus.rf_wdata, 32'h0);

    drive(1, 1, 1, 5'd9, 32'h8180FF7F, 32'h100, SIZE_BYTE, 0);
    step();
    chk("lb_off0", bus.rf_wdata, 32'hFFFFFF81);
    drive(1, 1, 1, 5'd9, 32'h8180FF7F, 32'h103, SIZE_BYTE, 1);
    step();
    chk("lbu_off3", bus.rf_wdata, 32'h0000007F);
    drive(1, 1, 1, 5'd9, 32'h8180FF7F, 32'h102, SIZE_HALF, 0);
    step();
    chk("lh_off2", bus.rf_wdata, 32'hFFFFFF7F);
    drive(1, 1, 1, 5'd9, 32'h8180FF7F, 32'h100, SIZE_HALF, 1);
    step();
    chk("lhu_off0", bus.rf_wdata, 32'h00008180);
    drive(1, 1, 1, 5'd9, 32'h8180FF7F, 32'h101, SIZE_BYTE, 0);
    step();
    chk("lb_off1", bus.rf_wdata, 32'hFFFFFF80);
    drive(1, 1, 1, 5'd9, 32'h8180FF7F, 32'h102, SIZE_BYTE, 1);
    step();
    chk("lbu_off2", bus.rf_wdata, 32'h000000FF);
    drive(1, 1, 1, 5'd9, 32'h8180FF7F, 32'h103, 2'b11, 0);
    step();
    chk("size11_word", bus.rf_wdata, 32'h8180FF7F);
    drive(1, 0, 1, 5'd9, 32'h8180FF7F, 32'h00000082, SIZE_BYTE, 0);
    step();
    chk("alu_ign_size", bus.rf_wdata, 32'h00000082);

    drive(1, 0, 1, 5'd0, 32'h0, 32'h12345678, SIZE_WORD, 0);
    step();
    chk("r0_we", {31'b0, bus.rf_we}, 32'h0);
    chk("r0_wdata", bus.rf_wdata, 32'h12345678);

    drive(0, 0, 1, 5'd10, 32'h0, 32'h55, SIZE_WORD, 0);
    step();
    chk("inv_we", {31'b0, bus.rf_we}, 32'h0);
    chk("inv_valid", {31'b0, bus.wb_valid}, 32'h0);

    drive(1, 0, 1, 5'd11, 32'h0, 32'hCAFEF00D, SIZE_WORD, 0);
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 5'(12 + i), 32'h0, 32'h1000 + 32'(i), SIZE_WORD, 0);
      step();
      chk("stall_wdata", bus.rf_wdata, 32'hCAFEF00D);
      chk("stall_waddr", {27'b0, bus.rf_waddr}, 32'd11);
      chk("stall_we", {31'b0, bus.rf_we}, 32'h1);
    end
    bus.flush = 1'b1;
    step();
    chk("flush_we", {31'b0, bus.rf_we}, 32'h0);
    chk("flush_valid", {31'b0, bus.wb_valid}, 32'h0);
    chk("flush_wdata", bus.rf_wdata, 32'h0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    drive(1, 0, 1, 5'd20, 32'h0, 32'hA5A5A5A5, SIZE_WORD, 0);
    step();
    chk("pre_rst_we", {31'b0, bus.rf_we}, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_we", {31'b0, bus.rf_we}, 32'h0);
    chk("arst_waddr", {27'b0, bus.rf_waddr}, 32'h0);
    chk("arst_wdata", bus.rf_wdata, 32'h0);
    chk("arst_valid", {31'b0, bus.wb_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("after_rst_wdata", bus.rf_wdata, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- MIPS pipeline write-back stage: MEM/WB pipeline register plus the result-select mux (memory load data vs ALU result) driving the register-file write port.
- Formats sub-word loads (byte/halfword, signed/unsigned, big-endian lane select).
- Suppresses writes to $0.
- Exposes the committed write for forwarding into EX.

Parameters:
- DATA_W, 32, datapath width (only 32 supported).
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold the MEM/WB register contents.
- flush  in  1  load a bubble into the MEM/WB register.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_to_reg  in  1  1 selects load data, 0 selects ALU result.
- reg_write  in  1  instruction writes the register file.
- write_reg  in  REG_ADDR_W  destination register.
- read_data  in  DATA_W  raw aligned word from data memory.
- alu_result  in  DATA_W  ALU result; bits [1:0] are the load byte offset.
- mem_size  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- mem_unsigned  in  1  1 zero-extends sub-word loads (LBU/LHU).
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data (write_data).
- wb_valid  out  1  stage holds a real instruction.

Behaviour:
- Reset (rst_n=0, asynchronous): all pipeline state clears to 0, so rf_we=0, rf_waddr=0, rf_wdata=0, wb_valid=0. Outputs remain 0 until the first clk edge after release.
- Each rising clk edge, highest priority first:
  - flush=1: capture a bubble (valid=0, reg_write=0, data fields 0).
  - else stall=1: hold all state.
  - else capture all MEM inputs.
- Flush beats stall when both are asserted.
- Latency: one cycle from the MEM inputs to the outputs. All outputs are functions of registered state only; no combinational input-to-output path.
- Load formatting uses the captured offset = alu_result[1:0]; big-endian lane select.
  - byte: offset 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - half: offset[1]=0 → [31:16], 1 → [15:0]; offset[0] is ignored (no alignment trap here).
  - word: pass read_data through unchanged.
  - Sign-extend when mem_unsigned=0, zero-extend when 1.
- rf_wdata = formatted load data if the captured mem_to_reg=1, else the captured alu_result. When mem_to_reg=0, mem_size and mem_unsigned are ignored.
- rf_we = valid & reg_write & (write_reg != 0). Writes to $0 never assert rf_we; rf_wdata is still driven.
- rf_waddr = captured write_reg; wb_valid = captured valid.
- mem_valid=0 is captured as a bubble: rf_we=0 regardless of reg_write.
- Reset asserted mid-operation discards the in-flight instruction immediately.

Decomposition:
- Shared package mips_pkg:
  - DATA_W and REG_ADDR_W.
  - mem_size encoding constants: SIZE_WORD, SIZE_HALF, SIZE_BYTE.
  - struct type for the MEM/WB bundle.
- One combinational sub-module, load_formatter: read_data, offset, mem_size, mem_unsigned in; formatted word out. It is reused by any future MEM-stage bypass.
- Mux and pipeline register live in the top module.

Test Plan:
- Reset, then one MEM/WB capture with mem_to_reg=0, read_data=0x00000000, alu_result=0x00000001, reg_write=1, write_reg=8, valid → next edge: rf_wdata=0x00000001, rf_we=1, rf_waddr=8. Then mem_to_reg=1, mem_size=word, same data → rf_wdata=0x00000000.
- Sub-word loads, read_data=0x8180FF7F:
  - LB offset 0 → 0xFFFFFF81.
  - LBU offset 3 → 0x0000007F.
  - LH offset 2 → 0xFFFFFF7F.
  - LHU offset 0 → 0x00008180.
- write_reg=0 with reg_write=1, alu_result=0x12345678 → rf_we=0, rf_wdata=0x12345678. mem_valid=0 → rf_we=0, wb_valid=0.
- Stall held 3 cycles while inputs change → outputs frozen. Flush and stall together → bubble (rf_we=0, wb_valid=0).
- Assert rst_n=0 between clock edges while rf_we=1 → all outputs 0 immediately, without waiting for a clock edge.
